mips_muldiv: RTL and testbench
==============================

Name: mips_muldiv

Overview:
- Iterative multiply/divide unit for the MIPS CPU execute stage. It sits directly downstream of the opcode/funct decode and ALU control path.
- It consumes decoded MULT/MULTU/DIV/DIVU requests with two register operands and produces the architectural HI/LO pair.
- HI/LO are read by MFHI/MFLO and written directly by MTHI/MTLO.
- It reports busy so the pipeline can stall on an access to HI/LO while an operation is in progress.

Parameters:
- WIDTH, 32, operand width. Iteration count equals WIDTH.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  request strobe; sampled only while idle
- op  input  2  operation: 0 = MULTU, 1 = MULT, 2 = DIVU, 3 = DIV
- a  input  WIDTH  rs operand (multiplicand or dividend)
- b  input  WIDTH  rt operand (multiplier or divisor)
- wr_hi  input  1  MTHI write strobe
- wr_lo  input  1  MTLO write strobe
- wdata  input  WIDTH  MTHI/MTLO data
- hi  output  WIDTH  HI register: product upper half or remainder
- lo  output  WIDTH  LO register: product lower half or quotient
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse when hi/lo take a new result

Behaviour:
- Reset (asynchronous, any state):
  - state goes to IDLE
  - hi = 0, lo = 0, busy = 0, done = 0
  - iteration counter and all internal accumulators cleared
  - an in-flight operation is discarded and no done pulse is produced
- States: IDLE, RUN, FIX.
- IDLE:
  - start = 1 latches op, a, b at edge E0, enters RUN, busy = 1 from E0.
  - Signed ops (MULT, DIV) latch the absolute values and record the operand signs.
  - start = 0: wr_hi loads hi <= wdata and wr_lo loads lo <= wdata. Both may fire in the same cycle.
  - start = 1 together with wr_hi/wr_lo: start wins and the writes are dropped.
- RUN:
  - Exactly WIDTH iterations on edges E1..E(WIDTH); the counter runs 0..WIDTH-1 and then FIX is entered.
  - Multiply: radix-2 shift-add over a 2*WIDTH-bit accumulator.
  - Divide: restoring shift-subtract. Each step computes a 1-bit-wider trial subtraction of the divisor from the partial remainder.
  - start, wr_hi and wr_lo are ignored.
  - hi and lo hold their previous values.
- FIX, at edge E(WIDTH+1):
  - Apply the sign correction and write hi/lo.
  - done = 1 for exactly the following cycle, then busy = 0, then return to IDLE.
  - Total latency is start sampled at E0 to done high after E(WIDTH+1), i.e. 33 edges for WIDTH = 32.
- Back-to-back: a start asserted during the done cycle is accepted, because the unit is in IDLE. The new busy rises at that edge.
- Sign rules:
  - MULT: product is negated (2*WIDTH-bit two's complement) if sign(a) xor sign(b).
  - DIV: quotient (lo) is negated if sign(a) xor sign(b); remainder (hi) takes the sign of a.
  - Unsigned ops perform no correction.
- Overflow: DIV of 0x80000000 by 0xFFFFFFFF gives lo = 0x80000000, hi = 0. This follows naturally from magnitude wrap; no special case is needed.
- Divide by zero: same latency, done still pulses.
  - DIVU: lo = all ones, hi = a.
  - DIV: lo = all ones if a >= 0, else 1; hi = a (original signed value).
- Width rules: all arithmetic is modulo 2^WIDTH per half; no exceptions or flags are raised.

Test Plan:
- Reset mid-RUN:
  - Stimulus: MULTU 5 x 7, assert reset at cycle 10.
  - Required: hi = lo = 0, busy = 0, and no done pulse on any later cycle.
- MULTU:
  - Stimulus: a = 0xFFFFFFFF, b = 0xFFFFFFFF.
  - Required: done exactly 33 edges after start; hi = 0xFFFFFFFE, lo = 0x00000001; busy high for 33 cycles.
- MULT:
  - Stimulus: a = -3 (0xFFFFFFFD), b = 7.
  - Required: hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
- DIV:
  - Stimulus: a = -7, b = 2.
  - Required: lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
- DIVU and DIV overflow:
  - Stimulus: DIVU 100/0, then DIV 0x80000000 / 0xFFFFFFFF.
  - Required: first gives lo = 0xFFFFFFFF, hi = 100; second gives lo = 0x80000000, hi = 0.
- Writes and back-to-back start:
  - Stimulus: wr_hi = 1 with wdata = 0x1234 while busy.
  - Required: hi unchanged.
  - Stimulus: wr_lo = 1 with wdata = 0xABCD in IDLE.
  - Required: lo = 0xABCD.
  - Stimulus: start during the done cycle.
  - Required: accepted, and a second done occurs 33 edges later.

Source files
------------

// File: rtl/mips_muldiv.sv
// mips_muldiv -- iterative multiply/divide unit holding the architectural HI/LO pair.
//
// MULT/MULTU use a radix-2 shift-add over a 2*WIDTH accumulator; DIV/DIVU use a
// restoring shift-subtract. Signed ops work on magnitudes and apply the sign
// correction in a final FIX cycle. Latency from accepted start to done is
// WIDTH+1 edges; busy covers exactly that window.
//
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   start, op, a, b  request strobe (sampled in IDLE), op code, rs/rt operands
//                    op: 0 = MULTU, 1 = MULT, 2 = DIVU, 3 = DIV
//   wr_hi, wr_lo, wdata  MTHI/MTLO writes (honoured in IDLE without start)
//   hi, lo         architectural HI/LO
//   busy           operation in progress
//   done           one-cycle pulse when hi/lo take a new result
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t state, state_nx;

   logic [CW-1:0]      cnt;
   logic               op_div;     // op[1]: divide
   logic               op_sgn;     // op[0]: signed
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   opnd;       // multiplicand magnitude or divisor magnitude
   logic [2*WIDTH-1:0] acc;        // mul: {partial product, multiplier}; div: {remainder, quotient}

   // Operand magnitudes at the request edge; unsigned ops never see a sign.
   logic             in_sa, in_sb;
   logic [WIDTH-1:0] in_ma, in_mb;

   always_comb begin
      in_sa = op[0] & a[WIDTH-1];
      in_sb = op[0] & b[WIDTH-1];
      in_ma = in_sa ? -a : a;
      in_mb = in_sb ? -b : b;
   end

   // One iteration of each algorithm.
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {mul_sum, acc[WIDTH-1:1]};
      // Remainder shifted left with the next dividend bit; the extra top bit
      // keeps the trial subtraction exact, its borrow selects restore.
      rem_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      trial    = rem_sh - {1'b0, opnd};
      if (trial[WIDTH])
         div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Sign correction. A zero divisor yields quotient magnitude all ones and
   // remainder |a|, which the same rules turn into the required results.
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      prod   = (op_sgn && (sign_a ^ sign_b)) ? -acc : acc;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (op_div) begin
         fix_lo = (op_sgn && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
         fix_hi = (op_sgn && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = RUN;
         RUN:     if (cnt == LAST) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Datapath and architectural registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         cnt    <= '0;
         op_div <= 1'b0;
         op_sgn <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         opnd   <= '0;
         acc    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  // start takes priority over MTHI/MTLO in the same cycle
                  op_div <= op[1];
                  op_sgn <= op[0];
                  sign_a <= in_sa;
                  sign_b <= in_sb;
                  opnd   <= op[1] ? in_mb : in_ma;
                  acc    <= {{WIDTH{1'b0}}, (op[1] ? in_ma : in_mb)};
                  cnt    <= '0;
                  busy   <= 1'b1;
               end else begin
                  if (wr_hi) hi <= wdata;
                  if (wr_lo) lo <= wdata;
               end
            end
            RUN: begin
               acc <= op_div ? div_next : mul_next;
               cnt <= cnt + 1'b1;
            end
            FIX: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               done <= 1'b1;
               busy <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv (WIDTH = 32).
module tb_mips_muldiv;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'd0;
   logic [31:0] a     = '0;
   logic [31:0] b     = '0;
   logic        wr_hi = 1'b0;
   logic        wr_lo = 1'b0;
   logic [31:0] wdata = '0;
   logic [31:0] hi, lo;
   logic        busy, done;

   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [1:0] MULTU = 2'd0, MULT = 2'd1, DIVU = 2'd2, DIV = 2'd3;

   mips_muldiv #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Launch one op from a negedge and return at the negedge where done is
   // seen. edges = posedges after the start edge (-1 on timeout), bcnt = cycles
   // with busy high.
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output int edges, output int bcnt);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      edges = -1;
      bcnt  = busy ? 1 : 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock); @(negedge clock);
         if (busy) bcnt++;
         if (done) begin edges = n; break; end
      end
   endtask

   task automatic test_reset;
      @(negedge clock);
      n_cmp++; if (hi !== 32'h0)  begin n_bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
      n_cmp++; if (lo !== 32'h0)  begin n_bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
      reset = 1'b0;
      @(negedge clock);
   endtask

   task automatic test_reset_mid_run;
      int dcnt;
      // make hi/lo nonzero so the clear is visible
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h5A5A_0001;
      @(posedge clock); @(negedge clock);
      wr_hi = 1'b0; wr_lo = 1'b0;
      op = MULTU; a = 32'd5; b = 32'd7; start = 1'b1;
      @(posedge clock); @(negedge clock);
      start = 1'b0;
      repeat (9) begin @(posedge clock); @(negedge clock); end
      reset = 1'b1;
      #1;
      n_cmp++; if (hi !== 32'h0)  begin n_bad++; $display("FAIL midrun_hi: got %h want %h", hi, 32'h0); end
      n_cmp++; if (lo !== 32'h0)  begin n_bad++; $display("FAIL midrun_lo: got %h want %h", lo, 32'h0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_busy: got %b want 0", busy); end
      @(negedge clock);
      reset = 1'b0;
      dcnt = 0;
      repeat (40) begin
         @(posedge clock); @(negedge clock);
         if (done) dcnt++;
      end
      n_cmp++; if (dcnt !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d pulses want 0", dcnt); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrun_busy_after: got %b want 0", busy); end
   endtask

   task automatic test_multu;
      int e, bc;
      run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e, bc);
      n_cmp++; if (e !== 33)  begin n_bad++; $display("FAIL multu_latency: got %0d want 33", e); end
      n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
      n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFF_FFFE); end
      n_cmp++; if (lo !== 32'h0000_0001) begin n_bad++; $display("FAIL multu_lo: got %h want %h", lo, 32'h1); end
      @(posedge clock); @(negedge clock);
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL multu_done_width: got %b want 0", done); end
   endtask

   task automatic test_mult;
      int e, bc;
      run_op(MULT, 32'hFFFF_FFFD, 32'd7, e, bc);
      n_cmp++; if (e !== 33) begin n_bad++; $display("FAIL mult_latency: got %0d want 33", e); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
      n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_bad++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFF_FFEB); end
      @(negedge clock);
   endtask

   task automatic test_div;
      int e, bc;
      run_op(DIV, 32'hFFFF_FFF9, 32'd2, e, bc);
      n_cmp++; if (e !== 33) begin n_bad++; $display("FAIL div_latency: got %0d want 33", e); end
      n_cmp++; if (lo !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL div_lo: got %h want %h", lo, 32'hFFFF_FFFD); end
      n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL div_hi: got %h want %h", hi, 32'hFFFF_FFFF); end
      @(negedge clock);
   endtask

   task automatic test_div_edge;
      int e, bc;
      run_op(DIVU, 32'd100, 32'd0, e, bc);
      n_cmp++; if (e !== 33) begin n_bad++; $display("FAIL divu0_latency: got %0d want 33", e); end
      n_cmp++; if (lo !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL divu0_lo: got %h want %h", lo, 32'hFFFF_FFFF); end
      n_cmp++; if (hi !== 32'd100) begin n_bad++; $display("FAIL divu0_hi: got %h want %h", hi, 32'd100); end
      @(negedge clock);
      run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, e, bc);
      n_cmp++; if (lo !== 32'h8000_0000) begin n_bad++; $display("FAIL divovf_lo: got %h want %h", lo, 32'h8000_0000); end
      n_cmp++; if (hi !== 32'h0) begin n_bad++; $display("FAIL divovf_hi: got %h want %h", hi, 32'h0); end
      @(negedge clock);
      // signed divide of a negative dividend by zero: lo = 1, hi = a
      run_op(DIV, 32'hFFFF_FFFB, 32'd0, e, bc);
      n_cmp++; if (lo !== 32'h1) begin n_bad++; $display("FAIL div0neg_lo: got %h want %h", lo, 32'h1); end
      n_cmp++; if (hi !== 32'hFFFF_FFFB) begin n_bad++; $display("FAIL div0neg_hi: got %h want %h", hi, 32'hFFFF_FFFB); end
      @(negedge clock);
   endtask

   task automatic test_writes;
      int e;
      // both writes in one idle cycle
      wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h77;
      @(posedge clock); @(negedge clock);
      wr_hi = 1'b0; wr_lo = 1'b0;
      n_cmp++; if (hi !== 32'h77) begin n_bad++; $display("FAIL wr_both_hi: got %h want %h", hi, 32'h77); end
      n_cmp++; if (lo !== 32'h77) begin n_bad++; $display("FAIL wr_both_lo: got %h want %h", lo, 32'h77); end
      // MTHI while busy is ignored
      op = MULTU; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clock); @(negedge clock);
      start = 1'b0; wr_hi = 1'b1; wdata = 32'h1234;
      repeat (5) begin @(posedge clock); @(negedge clock); end
      wr_hi = 1'b0;
      n_cmp++; if (hi !== 32'h77) begin n_bad++; $display("FAIL wr_busy_hi: got %h want %h", hi, 32'h77); end
      e = -1;
      for (int n = 6; n <= 40; n++) begin
         @(posedge clock); @(negedge clock);
         if (done) begin e = n; break; end
      end
      n_cmp++; if (e !== 33) begin n_bad++; $display("FAIL wr_busy_latency: got %0d want 33", e); end
      n_cmp++; if (lo !== 32'd12) begin n_bad++; $display("FAIL wr_busy_result: got %h want %h", lo, 32'd12); end
      @(negedge clock);
      // MTLO in idle
      wr_lo = 1'b1; wdata = 32'hABCD;
      @(posedge clock); @(negedge clock);
      wr_lo = 1'b0;
      n_cmp++; if (lo !== 32'hABCD) begin n_bad++; $display("FAIL wr_idle_lo: got %h want %h", lo, 32'hABCD); end
      // start together with MTLO: start wins
      op = MULTU; a = 32'd2; b = 32'd2; start = 1'b1; wr_lo = 1'b1; wdata = 32'h5555;
      @(posedge clock); @(negedge clock);
      start = 1'b0; wr_lo = 1'b0;
      n_cmp++; if (lo !== 32'hABCD) begin n_bad++; $display("FAIL wr_start_lo: got %h want %h", lo, 32'hABCD); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_start_busy: got %b want 1", busy); end
      e = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clock); @(negedge clock);
         if (done) begin e = n; break; end
      end
      n_cmp++; if (lo !== 32'd4) begin n_bad++; $display("FAIL wr_start_result: got %h want %h", lo, 32'd4); end
      @(negedge clock);
   endtask

   task automatic test_back_to_back;
      int e, bc;
      run_op(MULTU, 32'd6, 32'd7, e, bc);
      n_cmp++; if (lo !== 32'd42) begin n_bad++; $display("FAIL b2b_first_lo: got %h want %h", lo, 32'd42); end
      // still in the done cycle: next start is accepted immediately
      run_op(DIVU, 32'd100, 32'd7, e, bc);
      n_cmp++; if (e !== 33)  begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", e); end
      n_cmp++; if (bc !== 33) begin n_bad++; $display("FAIL b2b_busy_cycles: got %0d want 33", bc); end
      n_cmp++; if (lo !== 32'd14) begin n_bad++; $display("FAIL b2b_lo: got %h want %h", lo, 32'd14); end
      n_cmp++; if (hi !== 32'd2)  begin n_bad++; $display("FAIL b2b_hi: got %h want %h", hi, 32'd2); end
      @(negedge clock);
   endtask

   initial begin
      test_reset;
      test_reset_mid_run;
      test_multu;
      test_mult;
      test_div;
      test_div_edge;
      test_writes;
      test_back_to_back;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
